parking_lot_ctrl: RTL

PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

---
 rtl/parking_pkg.sv | 28 ++
 rtl/parking_lot_ctrl_lane_fsm.sv | 89 ++++++++
 rtl/parking_lot_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared constants for the parking lot controller: lane FSM state encoding,
// sensor-pair codes and a small popcount helper.
package parking_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IN_A   = 3'd1;
    localparam logic [2:0] ST_IN_AB  = 3'd2;
    localparam logic [2:0] ST_IN_B   = 3'd3;
    localparam logic [2:0] ST_OUT_B  = 3'd4;
    localparam logic [2:0] ST_OUT_AB = 3'd5;
    localparam logic [2:0] ST_OUT_A  = 3'd6;

    // Sensor pair codes as {a (outer), b (inner)}, 1 = beam cut
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_BOTH = 2'b11;
    localparam logic [1:0] AB_B    = 2'b01;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_lot_ctrl_lane_fsm.sv
// One sensor-pair lane: tracks a vehicle through the a/b beams and pulses
// entry or exit for one cycle when a full passage completes.
module lane_fsm
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic       entry,
    output logic       exit
);

    logic [2:0] state_q, state_d;
    logic       entry_q, entry_d;
    logic       exit_q,  exit_d;

    // Next state: step forward, step back, or hold on anything else
    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ab == AB_A)       state_d = ST_IN_A;
                else if (ab == AB_B)  state_d = ST_OUT_B;
                else                  state_d = state_q;
            end
            ST_IN_A: begin
                if (ab == AB_BOTH)      state_d = ST_IN_AB;
                else if (ab == AB_NONE) state_d = ST_IDLE;
                else                    state_d = state_q;
            end
            ST_IN_AB: begin
                if (ab == AB_B)       state_d = ST_IN_B;
                else if (ab == AB_A)  state_d = ST_IN_A;
                else                  state_d = state_q;
            end
            ST_IN_B: begin
                if (ab == AB_NONE) begin
                    state_d = ST_IDLE;
                    entry_d = 1'b1;
                end else if (ab == AB_BOTH) begin
                    state_d = ST_IN_AB;
                end else begin
                    state_d = state_q;
                end
            end
            ST_OUT_B: begin
                if (ab == AB_BOTH)      state_d = ST_OUT_AB;
                else if (ab == AB_NONE) state_d = ST_IDLE;
                else                    state_d = state_q;
            end
            ST_OUT_AB: begin
                if (ab == AB_A)       state_d = ST_OUT_A;
                else if (ab == AB_B)  state_d = ST_OUT_B;
                else                  state_d = state_q;
            end
            ST_OUT_A: begin
                if (ab == AB_NONE) begin
                    state_d = ST_IDLE;
                    exit_d  = 1'b1;
                end else if (ab == AB_BOTH) begin
                    state_d = ST_OUT_AB;
                end else begin
                    state_d = state_q;
                end
            end
            // Unused encoding recovers to IDLE
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            exit_q  <= exit_d;
        end
    end

    assign entry = entry_q;
    assign exit  = exit_q;

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking lot occupancy controller: N_LANES independent sensor lanes feed a
// saturating occupancy counter with full/empty decodes and a clamp flag.
module parking_lot_ctrl
    import parking_pkg::*;
#(
    parameter int N_LANES  = 2,
    parameter int CAPACITY = 100,
    localparam int CNT_W   = $clog2(CAPACITY + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*N_LANES-1:0]   ab,
    output logic [N_LANES-1:0]     entry,
    output logic [N_LANES-1:0]     exit,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic                   clamp_err
);

    localparam int NET_W = CNT_W + 4;
    localparam logic signed [NET_W-1:0] CAP_NET = NET_W'(CAPACITY);
    localparam logic [CNT_W-1:0]        CAP_CNT = CNT_W'(CAPACITY);

    logic [7:0]              ent_vec_s, ext_vec_s;
    logic [3:0]              n_ent_s, n_ext_s;
    logic signed [NET_W-1:0] net_sum_s;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    clamp_err_q, clamp_err_d;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_fsm u_lane (
            .clk   (clk),
            .reset (reset),
            .ab    (ab[2*g+1:2*g]),
            .entry (entry[g]),
            .exit  (exit[g])
        );
    end

    // Pack lane pulses into fixed-width vectors and count them
    always_comb begin
        ent_vec_s = 8'd0;
        ext_vec_s = 8'd0;
        for (int i = 0; i < N_LANES; i++) begin
            ent_vec_s[i] = entry[i];
            ext_vec_s[i] = exit[i];
        end
        n_ent_s = popcount8(ent_vec_s);
        n_ext_s = popcount8(ext_vec_s);
    end

    // Net all lanes first, then saturate; the extra 4 bits keep the sum from wrapping
    always_comb begin
        net_sum_s   = NET_W'(count_q) + NET_W'(n_ent_s) - NET_W'(n_ext_s);
        count_d     = count_q;
        clamp_err_d = 1'b0;
        if (net_sum_s[NET_W-1]) begin
            count_d     = {CNT_W{1'b0}};
            clamp_err_d = 1'b1;
        end else if (net_sum_s > CAP_NET) begin
            count_d     = CAP_CNT;
            clamp_err_d = 1'b1;
        end else begin
            count_d     = net_sum_s[CNT_W-1:0];
            clamp_err_d = 1'b0;
        end
    end

    // Occupancy and clamp flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= {CNT_W{1'b0}};
            clamp_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            clamp_err_q <= clamp_err_d;
        end
    end

    assign count     = count_q;
    assign clamp_err = clamp_err_q;
    assign full      = (count_q == CAP_CNT);
    assign empty     = (count_q == {CNT_W{1'b0}});

endmodule
